// File: rtl/alarm_pkg.sv
// Shared types and widths for the alarm ringer: FSM states, BCD digit widths
// and the ring/snooze timer width.
package alarm_pkg;

    localparam int TIMER_W      = 9;
    localparam int MIN_UNITS_W  = 4;
    localparam int MIN_TENS_W   = 3;
    localparam int HOUR_UNITS_W = 4;
    localparam int HOUR_TENS_W  = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RING   = 2'd1,
        ST_SNOOZE = 2'd2
    } ring_state_e;

endpackage

// File: rtl/alarm_sec_timer.sv
// Loadable down counter stepped by the 1 Hz tick; strobes expire on the tick
// that moves it off 1. Holds at zero rather than wrapping.
module alarm_sec_timer
    import alarm_pkg::*;
(
    input  logic               clk,
    input  logic               clr,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    input  logic               tick,
    output logic               expire
);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;

    // A load on the same cycle as a tick wins, so a fresh interval starts full.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (tick && (count_q != '0)) begin
            count_d = count_q - TIMER_W'(1);
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = tick && (count_q == TIMER_W'(1));

endmodule

// File: rtl/alarm_ringer.sv
// Compares the selected alarm time with the running clock and drives the
// buzzer, with ring timeout, limited snooze, stop and a sticky missed flag.
module alarm_ringer
    import alarm_pkg::*;
#(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int MAX_SNOOZE  = 3
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    tick,
    input  logic                    arm,
    input  logic [MIN_UNITS_W-1:0]  am0,
    input  logic [MIN_TENS_W-1:0]   am1,
    input  logic [HOUR_UNITS_W-1:0] ah0,
    input  logic [HOUR_TENS_W-1:0]  ah1,
    input  logic [MIN_UNITS_W-1:0]  cm0,
    input  logic [MIN_TENS_W-1:0]   cm1,
    input  logic [HOUR_UNITS_W-1:0] ch0,
    input  logic [HOUR_TENS_W-1:0]  ch1,
    input  logic                    snz,
    input  logic                    stp,
    output logic                    ringing,
    output logic                    buzz,
    output logic                    snoozing,
    output logic [1:0]              snooze_left,
    output logic                    missed
);

    localparam logic [TIMER_W-1:0] RING_LOAD   = TIMER_W'(RING_SECS);
    localparam logic [TIMER_W-1:0] SNOOZE_LOAD = TIMER_W'(SNOOZE_SECS);
    localparam logic [1:0]         SNOOZE_MAX  = 2'(MAX_SNOOZE);

    ring_state_e        state_q, state_d;
    logic               match_d_q;
    logic               phase_q, phase_d;
    logic [1:0]         snooze_left_q, snooze_left_d;
    logic               missed_q, missed_d;

    logic               match;
    logic               trig;
    logic               timer_tick;
    logic               timer_load;
    logic [TIMER_W-1:0] timer_load_val;
    logic               timer_expire;

    // Only the rising edge of a match fires, so a whole matching minute is one event.
    assign match      = arm && ({ah1, ah0, am1, am0} == {ch1, ch0, cm1, cm0});
    assign trig       = match && !match_d_q;
    assign timer_tick = tick && (state_q != ST_IDLE);

    alarm_sec_timer u_timer (
        .clk      (clk),
        .clr      (clr),
        .load     (timer_load),
        .load_val (timer_load_val),
        .tick     (timer_tick),
        .expire   (timer_expire)
    );

    // Per-cycle priority: disarm, stop, snooze, tick, trigger.
    always_comb begin
        state_d        = state_q;
        phase_d        = phase_q;
        snooze_left_d  = snooze_left_q;
        missed_d       = missed_q;
        timer_load     = 1'b0;
        timer_load_val = RING_LOAD;

        if (!arm) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (stp) begin
                        missed_d = 1'b0;
                    end else if (trig) begin
                        state_d       = ST_RING;
                        timer_load    = 1'b1;
                        snooze_left_d = SNOOZE_MAX;
                        phase_d       = 1'b1;
                        missed_d      = 1'b0;
                    end
                end
                ST_RING: begin
                    if (stp) begin
                        state_d = ST_IDLE;
                    end else if (snz && (snooze_left_q != 2'd0)) begin
                        state_d        = ST_SNOOZE;
                        timer_load     = 1'b1;
                        timer_load_val = SNOOZE_LOAD;
                        snooze_left_d  = snooze_left_q - 2'd1;
                    end else if (timer_expire) begin
                        state_d  = ST_IDLE;
                        missed_d = 1'b1;
                    end else if (tick) begin
                        phase_d = !phase_q;
                    end
                end
                ST_SNOOZE: begin
                    if (stp) begin
                        state_d = ST_IDLE;
                    end else if (timer_expire) begin
                        state_d    = ST_RING;
                        timer_load = 1'b1;
                        phase_d    = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q       <= ST_IDLE;
            match_d_q     <= 1'b0;
            phase_q       <= 1'b0;
            snooze_left_q <= 2'd0;
            missed_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            match_d_q     <= match;
            phase_q       <= phase_d;
            snooze_left_q <= snooze_left_d;
            missed_q      <= missed_d;
        end
    end

    assign ringing     = (state_q == ST_RING);
    assign snoozing    = (state_q == ST_SNOOZE);
    assign buzz        = ringing && phase_q;
    assign snooze_left = snooze_left_q;
    assign missed      = missed_q;

endmodule
